// File: rtl/leaf_stream_adapter_if.sv
// Stream bundle between the leaf interface, the adapter and the HLS kernel.
// master = adapter side, slave = leaf interface plus kernel side.
interface leaf_stream_adapter_if #(
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_IN_PORTS  = 1,
  parameter int NUM_OUT_PORTS = 1
);
  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_leaf_interface2user;
  logic [NUM_IN_PORTS-1:0]               vld_interface2user;
  logic [NUM_IN_PORTS-1:0]               ack_user2interface;
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
  logic [NUM_OUT_PORTS-1:0]              ack_interface2user;
  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  kern_in_data;
  logic [NUM_IN_PORTS-1:0]               kern_in_vld;
  logic [NUM_IN_PORTS-1:0]               kern_in_ack;
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] kern_out_data;
  logic [NUM_OUT_PORTS-1:0]              kern_out_vld;
  logic [NUM_OUT_PORTS-1:0]              kern_out_ack;

  modport master (
    input  dout_leaf_interface2user, vld_interface2user, ack_interface2user,
           kern_in_ack, kern_out_data, kern_out_vld,
    output ack_user2interface, din_leaf_user2interface, vld_user2interface,
           kern_in_data, kern_in_vld, kern_out_ack
  );

  modport slave (
    output dout_leaf_interface2user, vld_interface2user, ack_interface2user,
           kern_in_ack, kern_out_data, kern_out_vld,
    input  ack_user2interface, din_leaf_user2interface, vld_user2interface,
           kern_in_data, kern_in_vld, kern_out_ack
  );
endinterface

// File: rtl/leaf_stream_adapter.sv
// Leaf stream <-> HLS ap_vld/ap_ack adapter: per-channel FWFT FIFOs plus ap_start FSM.
// Optional per-port word counters are enabled with `define LEAF_ADAPTER_STATS_EN.
module leaf_stream_adapter_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int ADDR_BITS = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int CW = ADDR_BITS + 1;

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  // Head is forced to zero while empty so stale storage never leaks out.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + ADDR_BITS'(push_i);
    rd_ptr_d = rd_ptr_q + ADDR_BITS'(pop_i);
    count_d  = count_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

module leaf_stream_adapter #(
  parameter int PAYLOAD_BITS   = 32,
  parameter int NUM_IN_PORTS   = 1,
  parameter int NUM_OUT_PORTS  = 1,
  parameter int FIFO_DEPTH     = 4,
  parameter int FIFO_ADDR_BITS = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ap_start,
  leaf_stream_adapter_if.master bus,
  output logic kern_ap_start,
  output logic busy
`ifdef LEAF_ADAPTER_STATS_EN
  ,
  output logic [NUM_IN_PORTS*32-1:0]  in_word_cnt,
  output logic [NUM_OUT_PORTS*32-1:0] out_word_cnt
`endif
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0] state_q, state_d;
  logic       active;
  logic       out_quiet;

  logic [NUM_IN_PORTS-1:0]  in_full, in_empty, in_push, in_pop;
  logic [NUM_OUT_PORTS-1:0] out_full, out_empty, out_push, out_pop;
  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  in_head;
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] out_head;

  assign active = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  // Acks depend only on FIFO status and state, never on the opposite-side valid.
  assign bus.ack_user2interface = ~in_full;
  assign bus.kern_in_vld        = ~in_empty & {NUM_IN_PORTS{active}};
  assign bus.kern_out_ack       = ~out_full & {NUM_OUT_PORTS{active}};
  assign bus.vld_user2interface = ~out_empty;
  assign bus.kern_in_data            = in_head;
  assign bus.din_leaf_user2interface = out_head;

  assign in_push  = bus.vld_interface2user & ~in_full;
  assign in_pop   = bus.kern_in_vld & bus.kern_in_ack;
  assign out_push = bus.kern_out_vld & bus.kern_out_ack;
  assign out_pop  = bus.vld_user2interface & bus.ack_interface2user;

  for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
    leaf_stream_adapter_fifo #(
      .WIDTH    (PAYLOAD_BITS),
      .DEPTH    (FIFO_DEPTH),
      .ADDR_BITS(FIFO_ADDR_BITS)
    ) u_fifo (
      .clk_i  (clk),
      .reset_i(reset),
      .push_i (in_push[i]),
      .wdata_i(bus.dout_leaf_interface2user[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .pop_i  (in_pop[i]),
      .rdata_o(in_head[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .full_o (in_full[i]),
      .empty_o(in_empty[i])
    );
  end

  for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_out
    leaf_stream_adapter_fifo #(
      .WIDTH    (PAYLOAD_BITS),
      .DEPTH    (FIFO_DEPTH),
      .ADDR_BITS(FIFO_ADDR_BITS)
    ) u_fifo (
      .clk_i  (clk),
      .reset_i(reset),
      .push_i (out_push[j]),
      .wdata_i(bus.kern_out_data[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .pop_i  (out_pop[j]),
      .rdata_o(out_head[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .full_o (out_full[j]),
      .empty_o(out_empty[j])
    );
  end

  assign out_quiet = (&out_empty) && !(|bus.kern_out_vld);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (ap_start) state_d = ST_RUN;
      ST_RUN:   if (!ap_start) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (ap_start)       state_d = ST_RUN;
        else if (out_quiet) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  assign kern_ap_start = (state_q == ST_RUN);
  assign busy          = (state_q != ST_IDLE);

`ifdef LEAF_ADAPTER_STATS_EN
  logic [NUM_IN_PORTS*32-1:0]  in_cnt_q;
  logic [NUM_OUT_PORTS*32-1:0] out_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_IN_PORTS; i++)
        if (in_push[i]) in_cnt_q[i*32 +: 32] <= in_cnt_q[i*32 +: 32] + 32'd1;
      for (int unsigned j = 0; j < NUM_OUT_PORTS; j++)
        if (out_pop[j]) out_cnt_q[j*32 +: 32] <= out_cnt_q[j*32 +: 32] + 32'd1;
    end
  end

  assign in_word_cnt  = in_cnt_q;
  assign out_word_cnt = out_cnt_q;
`endif
endmodule

// File: tb/tb_leaf_stream_adapter.sv
// Bench for leaf_stream_adapter (3 in / 2 out): vector table, corner sequences,
// random traffic against a queue-based reference model.
module tb_leaf_stream_adapter;
  localparam int NI = 3, NO = 2, W = 32, DEPTH = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;
  typedef logic [W-1:0] word_t;

  logic clk = 1'b0;
  logic reset, ap_start, kern_ap_start, busy;
  always #5 clk = ~clk;

  leaf_stream_adapter_if #(.PAYLOAD_BITS(W), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO)) bus ();

`ifdef LEAF_ADAPTER_STATS_EN
  logic [NI*32-1:0] in_word_cnt;
  logic [NO*32-1:0] out_word_cnt;
`endif

  leaf_stream_adapter #(
    .PAYLOAD_BITS(W), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO),
    .FIFO_DEPTH(DEPTH), .FIFO_ADDR_BITS(2)
  ) dut (
    .clk(clk), .reset(reset), .ap_start(ap_start), .bus(bus),
    .kern_ap_start(kern_ap_start), .busy(busy)
`ifdef LEAF_ADAPTER_STATS_EN
    , .in_word_cnt(in_word_cnt), .out_word_cnt(out_word_cnt)
`endif
  );

  int errors = 0, checks = 0;
  word_t qin [NI][$];
  word_t qout[NO][$];
  int mode;
  logic [31:0] m_in_cnt [NI];
  logic [31:0] m_out_cnt[NO];
  int sent[NI], recv[NI], ncyc;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic zero_inputs();
    bus.dout_leaf_interface2user = '0;
    bus.vld_interface2user = '0;
    bus.ack_interface2user = '0;
    bus.kern_in_ack = '0;
    bus.kern_out_data = '0;
    bus.kern_out_vld = '0;
  endtask

  task automatic check_outputs(input string tag);
    logic [NI-1:0] e_ack, e_kvld;
    logic [NO-1:0] e_koack, e_vldo;
    logic [NI*W-1:0] e_kdata;
    logic [NO*W-1:0] e_dout;
    for (int i = 0; i < NI; i++) begin
      e_ack[i]  = qin[i].size() < DEPTH;
      e_kvld[i] = qin[i].size() > 0 && mode != M_IDLE;
      e_kdata[i*W +: W] = (qin[i].size() > 0) ? qin[i][0] : '0;
    end
    for (int j = 0; j < NO; j++) begin
      e_koack[j] = qout[j].size() < DEPTH && mode != M_IDLE;
      e_vldo[j]  = qout[j].size() > 0;
      e_dout[j*W +: W] = (qout[j].size() > 0) ? qout[j][0] : '0;
    end
    chk({tag, ".ack_in"},   bus.ack_user2interface, e_ack);
    chk({tag, ".kin_vld"},  bus.kern_in_vld, e_kvld);
    chk({tag, ".kin_data"}, bus.kern_in_data, e_kdata);
    chk({tag, ".kout_ack"}, bus.kern_out_ack, e_koack);
    chk({tag, ".vld_out"},  bus.vld_user2interface, e_vldo);
    chk({tag, ".dout"},     bus.din_leaf_user2interface, e_dout);
    chk({tag, ".kap"},      kern_ap_start, mode == M_RUN);
    chk({tag, ".busy"},     busy, mode != M_IDLE);
`ifdef LEAF_ADAPTER_STATS_EN
    for (int i = 0; i < NI; i++) chk({tag, ".in_cnt"}, in_word_cnt[i*32 +: 32], m_in_cnt[i]);
    for (int j = 0; j < NO; j++) chk({tag, ".out_cnt"}, out_word_cnt[j*32 +: 32], m_out_cnt[j]);
`endif
  endtask

  // Advance the reference model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [NI-1:0] ipush, ipop;
    logic [NO-1:0] opush, opop;
    bit quiet;
    if (reset) begin
      for (int i = 0; i < NI; i++) begin qin[i].delete(); m_in_cnt[i] = '0; end
      for (int j = 0; j < NO; j++) begin qout[j].delete(); m_out_cnt[j] = '0; end
      mode = M_IDLE;
      return;
    end
    quiet = (bus.kern_out_vld == '0);
    for (int i = 0; i < NI; i++) begin
      ipush[i] = bus.vld_interface2user[i] && qin[i].size() < DEPTH;
      ipop[i]  = qin[i].size() > 0 && mode != M_IDLE && bus.kern_in_ack[i];
    end
    for (int j = 0; j < NO; j++) begin
      opush[j] = bus.kern_out_vld[j] && qout[j].size() < DEPTH && mode != M_IDLE;
      opop[j]  = qout[j].size() > 0 && bus.ack_interface2user[j];
      if (qout[j].size() > 0) quiet = 0;
    end
    for (int i = 0; i < NI; i++) begin
      if (ipop[i]) void'(qin[i].pop_front());
      if (ipush[i]) begin
        qin[i].push_back(bus.dout_leaf_interface2user[i*W +: W]);
        m_in_cnt[i] = m_in_cnt[i] + 32'd1;
      end
    end
    for (int j = 0; j < NO; j++) begin
      if (opop[j]) begin
        void'(qout[j].pop_front());
        m_out_cnt[j] = m_out_cnt[j] + 32'd1;
      end
      if (opush[j]) qout[j].push_back(bus.kern_out_data[j*W +: W]);
    end
    case (mode)
      M_IDLE:  if (ap_start) mode = M_RUN;
      M_RUN:   if (!ap_start) mode = M_DRAIN;
      default: if (ap_start) mode = M_RUN; else if (quiet) mode = M_IDLE;
    endcase
  endtask

  task automatic cycle(input string tag);
    #1;
    check_outputs(tag);
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic ap; logic vld; logic [31:0] d; logic kack; logic kovld; logic [31:0] kod; logic oack;
    logic e_ack; logic e_kvld; logic [31:0] e_kdata; logic e_koack; logic e_vldo;
    logic [31:0] e_dout; logic e_kap; logic e_busy;
  } vec_t;
  localparam int NT = 23;
  vec_t tbl[NT];

  function automatic vec_t mk(logic ap, logic vld, logic [31:0] d, logic kack, logic kovld,
                              logic [31:0] kod, logic oack, logic e_ack, logic e_kvld,
                              logic [31:0] e_kdata, logic e_koack, logic e_vldo,
                              logic [31:0] e_dout, logic e_kap, logic e_busy);
    vec_t v;
    v.ap = ap; v.vld = vld; v.d = d; v.kack = kack; v.kovld = kovld; v.kod = kod; v.oack = oack;
    v.e_ack = e_ack; v.e_kvld = e_kvld; v.e_kdata = e_kdata; v.e_koack = e_koack;
    v.e_vldo = e_vldo; v.e_dout = e_dout; v.e_kap = e_kap; v.e_busy = e_busy;
    return v;
  endfunction

  initial begin
    logic [31:0] a1, a2, a3, a4, a5, db;
    a1 = 32'h1111_1111; a2 = 32'h2222_2222; a3 = 32'h3333_3333;
    a4 = 32'h4444_4444; a5 = 32'h5555_5555; db = 32'hDEAD_BEEF;
    //            ap vld d   kack kovld kod oack | ack kvld kdata koack vldo dout kap busy
    tbl[0]  = mk(0, 1, a1, 0, 0, 0, 0,  1, 0, 0,  0, 0, 0,  0, 0);
    tbl[1]  = mk(0, 1, a2, 0, 0, 0, 0,  1, 0, a1, 0, 0, 0,  0, 0);
    tbl[2]  = mk(0, 1, a3, 0, 0, 0, 0,  1, 0, a1, 0, 0, 0,  0, 0);
    tbl[3]  = mk(1, 0, 0,  0, 0, 0, 0,  1, 0, a1, 0, 0, 0,  0, 0);
    tbl[4]  = mk(1, 0, 0,  0, 0, 0, 0,  1, 1, a1, 1, 0, 0,  1, 1);
    tbl[5]  = mk(1, 1, a4, 0, 0, 0, 0,  1, 1, a1, 1, 0, 0,  1, 1);
    tbl[6]  = mk(1, 1, a5, 0, 0, 0, 0,  0, 1, a1, 1, 0, 0,  1, 1);
    tbl[7]  = mk(1, 1, a5, 1, 0, 0, 0,  0, 1, a1, 1, 0, 0,  1, 1);
    tbl[8]  = mk(1, 1, a5, 0, 0, 0, 0,  1, 1, a2, 1, 0, 0,  1, 1);
    tbl[9]  = mk(1, 0, 0,  1, 0, 0, 0,  0, 1, a2, 1, 0, 0,  1, 1);
    tbl[10] = mk(1, 0, 0,  1, 0, 0, 0,  1, 1, a3, 1, 0, 0,  1, 1);
    tbl[11] = mk(1, 0, 0,  1, 0, 0, 0,  1, 1, a4, 1, 0, 0,  1, 1);
    tbl[12] = mk(1, 0, 0,  1, 0, 0, 0,  1, 1, a5, 1, 0, 0,  1, 1);
    tbl[13] = mk(1, 0, 0,  1, 0, 0, 0,  1, 0, 0,  1, 0, 0,  1, 1);
    tbl[14] = mk(1, 1, db, 0, 0, 0, 0,  1, 0, 0,  1, 0, 0,  1, 1);
    tbl[15] = mk(1, 0, 0,  1, 0, 0, 0,  1, 1, db, 1, 0, 0,  1, 1);
    tbl[16] = mk(1, 0, 0,  0, 1, db, 0, 1, 0, 0,  1, 0, 0,  1, 1);
    tbl[17] = mk(1, 0, 0,  0, 0, 0, 0,  1, 0, 0,  1, 1, db, 1, 1);
    tbl[18] = mk(1, 0, 0,  0, 0, 0, 1,  1, 0, 0,  1, 1, db, 1, 1);
    tbl[19] = mk(1, 0, 0,  0, 0, 0, 0,  1, 0, 0,  1, 0, 0,  1, 1);
    tbl[20] = mk(0, 0, 0,  0, 0, 0, 0,  1, 0, 0,  1, 0, 0,  1, 1);
    tbl[21] = mk(0, 0, 0,  0, 0, 0, 0,  1, 0, 0,  1, 0, 0,  0, 1);
    tbl[22] = mk(0, 0, 0,  0, 0, 0, 0,  1, 0, 0,  0, 0, 0,  0, 0);

    reset = 1'b1; ap_start = 1'b0; zero_inputs();
    model_step();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Vector table on port 0: IDLE gating, full FIFO, single word round trip, drain to idle.
    for (int r = 0; r < NT; r++) begin
      zero_inputs();
      ap_start = tbl[r].ap;
      bus.vld_interface2user[0] = tbl[r].vld;
      bus.dout_leaf_interface2user[31:0] = tbl[r].d;
      bus.kern_in_ack[0] = tbl[r].kack;
      bus.kern_out_vld[0] = tbl[r].kovld;
      bus.kern_out_data[31:0] = tbl[r].kod;
      bus.ack_interface2user[0] = tbl[r].oack;
      #1;
      chk($sformatf("tbl%0d.ack", r),   bus.ack_user2interface[0], tbl[r].e_ack);
      chk($sformatf("tbl%0d.kvld", r),  bus.kern_in_vld[0], tbl[r].e_kvld);
      chk($sformatf("tbl%0d.kdata", r), bus.kern_in_data[31:0], tbl[r].e_kdata);
      chk($sformatf("tbl%0d.koack", r), bus.kern_out_ack[0], tbl[r].e_koack);
      chk($sformatf("tbl%0d.vldo", r),  bus.vld_user2interface[0], tbl[r].e_vldo);
      chk($sformatf("tbl%0d.dout", r),  bus.din_leaf_user2interface[31:0], tbl[r].e_dout);
      chk($sformatf("tbl%0d.kap", r),   kern_ap_start, tbl[r].e_kap);
      chk($sformatf("tbl%0d.busy", r),  busy, tbl[r].e_busy);
      cycle("tbl");
    end

    // Drain with two pending output words, then DRAIN->RUN priority.
    zero_inputs(); ap_start = 1'b1; cycle("drn");
    bus.kern_out_vld[0] = 1'b1; bus.kern_out_data[31:0] = 32'hA0A0_0001; cycle("drn");
    bus.kern_out_data[31:0] = 32'hA0A0_0002; cycle("drn");
    bus.kern_out_vld = '0; ap_start = 1'b0; cycle("drn");
    chk("drain.busy", busy, 1'b1);
    chk("drain.kap", kern_ap_start, 1'b0);
    cycle("drn"); cycle("drn");
    chk("drain.hold_busy", busy, 1'b1);
    bus.ack_interface2user[0] = 1'b1; cycle("drn"); cycle("drn");
    bus.ack_interface2user[0] = 1'b0;
    chk("drain.empty_still_busy", busy, 1'b1);
    cycle("drn");
    chk("drain.idle", busy, 1'b0);
    ap_start = 1'b1; cycle("prio");
    bus.kern_out_vld[1] = 1'b1; bus.kern_out_data[63:32] = 32'hB0B0_0001; cycle("prio");
    bus.kern_out_vld = '0; ap_start = 1'b0; cycle("prio");
    chk("prio.drain_kap", kern_ap_start, 1'b0);
    ap_start = 1'b1; cycle("prio");
    chk("prio.rerun_kap", kern_ap_start, 1'b1);
    ap_start = 1'b0; bus.ack_interface2user = '1;
    repeat (4) cycle("prio");

    // Port independence: port 1 kernel stalled, ports 0 and 2 stream 16 words each.
    zero_inputs(); ap_start = 1'b1; cycle("mp");
    for (int i = 0; i < NI; i++) begin sent[i] = 0; recv[i] = 0; end
    ncyc = 0;
    while ((recv[0] < 16 || recv[2] < 16) && ncyc < 40) begin
      for (int i = 0; i < NI; i++) begin
        bus.vld_interface2user[i] = (sent[i] < 16);
        bus.dout_leaf_interface2user[i*W +: W] = {8'(i), 24'(sent[i])};
      end
      bus.kern_in_ack = 3'b101;
      #1;
      for (int i = 0; i < NI; i++) begin
        if (bus.vld_interface2user[i] && bus.ack_user2interface[i]) sent[i]++;
        if (bus.kern_in_vld[i] && bus.kern_in_ack[i]) begin
          chk($sformatf("mp.data%0d", i), bus.kern_in_data[i*W +: W], {8'(i), 24'(recv[i])});
          recv[i]++;
        end
      end
      cycle("mp");
      ncyc++;
    end
    chk("mp.recv0", 32'(recv[0]), 32'd16);
    chk("mp.recv2", 32'(recv[2]), 32'd16);
    chk("mp.recv1_stalled", 32'(recv[1]), 32'd0);
    chk("mp.cycles", 32'(ncyc), 32'd17);
    zero_inputs(); bus.kern_in_ack = '1;
    repeat (6) cycle("mp");
    ap_start = 1'b0;
    repeat (3) cycle("mp");

    // Reset with words buffered on both sides.
    ap_start = 1'b1; cycle("rst");
    for (int k = 0; k < 3; k++) begin
      bus.vld_interface2user[0] = 1'b1;
      bus.dout_leaf_interface2user[31:0] = $urandom();
      bus.kern_out_vld[1] = (k == 0);
      bus.kern_out_data[63:32] = 32'hC0C0_0000;
      cycle("rst");
    end
    zero_inputs(); ap_start = 1'b0; reset = 1'b1;
    cycle("rst");
    reset = 1'b0;
    #1;
    chk("rst.vld_out", bus.vld_user2interface, 2'b00);
    chk("rst.kin_vld", bus.kern_in_vld, 3'b000);
    chk("rst.ack_in", bus.ack_user2interface, 3'b111);
    chk("rst.busy", busy, 1'b0);
`ifdef LEAF_ADAPTER_STATS_EN
    chk("rst.in_cnt", in_word_cnt, '0);
    chk("rst.out_cnt", out_word_cnt, '0);
`endif
    repeat (3) cycle("rst");

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(15) == 0) ap_start = ~ap_start;
      bus.vld_interface2user = 3'($urandom());
      bus.dout_leaf_interface2user = {$urandom(), $urandom(), $urandom()};
      bus.kern_in_ack = 3'($urandom());
      bus.kern_out_vld = 2'($urandom());
      bus.kern_out_data = {$urandom(), $urandom()};
      bus.ack_interface2user = 2'($urandom());
      reset = ($urandom_range(499) == 0);
      cycle("rnd");
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
